vram_scheduler: RTL

Arbitrates the single-port video RAM between the display line fetcher and the CPU data port. The block sits between the VGA timing generator, the VRAM, and the double-buffered line buffer. On each display line it copies one line of pixel words from VRAM into the line-buffer half selected by `front`. CPU reads and writes are served in the idle gaps, and display fetch always has priority.

---
 rtl/vram_pkg.sv | 25 ++
 rtl/vram_fetch_ctr.sv | 50 +++++
 rtl/vram_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared state encoding, default geometry and line start-address rule for the VRAM scheduler.
package vram_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_LINE_WORDS = 40;
  localparam int DEF_LB_AW      = 6;
  localparam int Y_W            = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_ADDR = 3'd1,
    CPU_DATA = 3'd2,
    FETCH    = 3'd3,
    DRAIN    = 3'd4
  } sched_state_e;

  // First word of a display line; the caller truncates to its address width so the sum wraps.
  function automatic logic [31:0] line_start_addr(input logic [31:0]    base,
                                                  input logic [Y_W-1:0] y,
                                                  input logic [31:0]    words);
    return base + (32'(y) * words);
  endfunction

endpackage

// File: rtl/vram_fetch_ctr.sv
// Line-fetch word counter: start address, next read address, delayed line-buffer index, last-word flag.
module vram_fetch_ctr
  import vram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LB_AW      = DEF_LB_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] fb_base_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [ADDR_W-1:0] start_addr_o,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic [LB_AW-1:0]  lb_idx_o,
  output logic              last_o
);

  logic [LB_AW-1:0]  idx_q;
  logic [LB_AW-1:0]  lb_idx_q;
  logic [ADDR_W-1:0] base_q;

  assign start_addr_o = ADDR_W'(line_start_addr(32'(fb_base_i), y_i, 32'(LINE_WORDS)));
  assign next_addr_o  = base_q + ADDR_W'(idx_q) + ADDR_W'(1);
  assign last_o       = (idx_q == LB_AW'(LINE_WORDS - 1));
  assign lb_idx_o     = lb_idx_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q    <= {LB_AW{1'b0}};
      lb_idx_q <= {LB_AW{1'b0}};
      base_q   <= {ADDR_W{1'b0}};
    end else begin
      if (load_i) begin
        base_q <= start_addr_o;
        idx_q  <= {LB_AW{1'b0}};
      end else if (adv_i) begin
        idx_q <= idx_q + LB_AW'(1);
      end
      // Read data lands one cycle after its address, so the buffer index trails by one.
      if (issue_i) begin
        lb_idx_q <= idx_q;
      end
    end
  end

endmodule

// File: rtl/vram_scheduler.sv
// Single-port VRAM arbiter: display line fetch has priority, CPU accesses fill the gaps.
// Optional build macro VRAM_SCHED_OVERRUN_EN enables the sticky overrun flag.
module vram_scheduler
  import vram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LB_AW      = DEF_LB_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start_i,
  input  logic              vlookahead_i,
  input  logic [Y_W-1:0]    y_i,
  input  logic              front_i,
  input  logic [ADDR_W-1:0] fb_base_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              lb_we_o,
  output logic [LB_AW-1:0]  lb_addr_o,
  output logic              lb_sel_o,
  output logic [DATA_W-1:0] lb_wdata_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              overrun_o
);

  sched_state_e      state_q;
  logic              ls_prev_q;
  logic              pending_q;
  logic [Y_W-1:0]    cap_y_q;
  logic              cap_sel_q;
  logic              act_sel_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              lb_we_q;
  logic              lb_sel_q;
  logic              cpu_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic              new_req_s;
  logic              go_s;
  logic [Y_W-1:0]    fetch_y_s;
  logic              fetch_sel_s;
  logic [ADDR_W-1:0] start_addr_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [LB_AW-1:0]  lb_idx_s;
  logic              last_s;

  assign new_req_s = line_start_i & ~ls_prev_q & vlookahead_i;
  // An edge seen in IDLE with nothing queued starts straight from the live inputs.
  assign go_s        = (state_q == IDLE) && (pending_q || new_req_s);
  assign fetch_y_s   = pending_q ? cap_y_q   : y_i;
  assign fetch_sel_s = pending_q ? cap_sel_q : front_i;

  vram_fetch_ctr #(
    .ADDR_W    (ADDR_W),
    .LINE_WORDS(LINE_WORDS),
    .LB_AW     (LB_AW)
  ) u_fetch_ctr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (go_s),
    .adv_i       ((state_q == FETCH) && !last_s),
    .issue_i     (state_q == FETCH),
    .fb_base_i   (fb_base_i),
    .y_i         (fetch_y_s),
    .start_addr_o(start_addr_s),
    .next_addr_o (next_addr_s),
    .lb_idx_o    (lb_idx_s),
    .last_o      (last_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ls_prev_q   <= 1'b0;
      pending_q   <= 1'b0;
      cap_y_q     <= {Y_W{1'b0}};
      cap_sel_q   <= 1'b0;
      act_sel_q   <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_we_q    <= 1'b0;
      mem_wdata_q <= {DATA_W{1'b0}};
      lb_we_q     <= 1'b0;
      lb_sel_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= {DATA_W{1'b0}};
    end else begin
      ls_prev_q <= line_start_i;
      cpu_ack_q <= 1'b0;
      lb_we_q   <= 1'b0;

      if (new_req_s) begin
        cap_y_q   <= y_i;
        cap_sel_q <= front_i;
      end
      // A new edge re-arms pending unless IDLE consumes it directly this cycle.
      if (new_req_s && !(go_s && !pending_q)) begin
        pending_q <= 1'b1;
      end else if (go_s) begin
        pending_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (go_s) begin
            state_q    <= FETCH;
            mem_addr_q <= start_addr_s;
            mem_we_q   <= 1'b0;
            act_sel_q  <= fetch_sel_s;
          end else if (cpu_req_i && !cpu_ack_q) begin
            state_q     <= CPU_ADDR;
            mem_addr_q  <= cpu_addr_i;
            mem_we_q    <= cpu_we_i;
            mem_wdata_q <= cpu_wdata_i;
          end
        end
        CPU_ADDR: begin
          state_q  <= CPU_DATA;
          mem_we_q <= 1'b0;
        end
        CPU_DATA: begin
          cpu_rdata_q <= mem_rdata_i;
          cpu_ack_q   <= 1'b1;
          state_q     <= IDLE;
        end
        FETCH: begin
          lb_we_q  <= 1'b1;
          lb_sel_q <= act_sel_q;
          if (last_s) begin
            state_q <= DRAIN;
          end else begin
            mem_addr_q <= next_addr_s;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VRAM_SCHED_OVERRUN_EN
  logic overrun_q;
  logic busy_s;

  assign busy_s = (state_q == FETCH) || (state_q == DRAIN);

  // Sticky: a new line arrived while the previous one was still queued or being fetched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else if (new_req_s && (pending_q || busy_s)) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;
  assign lb_we_o     = lb_we_q;
  assign lb_addr_o   = lb_idx_s;
  assign lb_sel_o    = lb_sel_q;
  assign lb_wdata_o  = lb_we_q ? mem_rdata_i : {DATA_W{1'b0}};
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;

endmodule
